// File: rtl/jesd204_tpl_pkg.sv
// Shared constants for the JESD204 transport layer: frame geometry helper,
// PN9/PN23 definitions and the PN monitor state encoding.
package jesd204_tpl_pkg;

    localparam int OCTETS_PER_BEAT = 4;

    localparam int PN9_WIDTH  = 9;
    localparam int PN9_TAP    = 5;
    localparam int PN23_WIDTH = 23;
    localparam int PN23_TAP   = 18;

    localparam int PN_THRESH = 16;
    localparam int PN_CNT_W  = 5;

    typedef enum logic {
        PN_OOS  = 1'b0,
        PN_SYNC = 1'b1
    } pn_state_t;

    // Octets per frame F for L lanes and M 16-bit converters.
    function automatic int frame_octets(input int lanes, input int channels);
        return 2 * channels / lanes;
    endfunction

endpackage

// File: rtl/jesd204_tpl_adc_pnmon.sv
// Self-synchronising PN9/PN23 monitor for one channel; the beat is a bit stream,
// sample 0 MSB first. Lock/loss after PN_THRESH consecutive matching/mismatching beats.
module jesd204_tpl_adc_pnmon
    import jesd204_tpl_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic                          sel,
    input  logic [DATA_PATH_WIDTH*16-1:0] data,
    output logic                          oos,
    output logic                          err
);

    localparam int BEAT_BITS = DATA_PATH_WIDTH * 16;
    localparam int HW        = PN23_WIDTH;

    pn_state_t               state;
    logic [PN_CNT_W-1:0]     match_cnt;
    logic [PN_CNT_W-1:0]     miss_cnt;
    logic [HW-1:0]           hist;
    logic                    sel_d;
    logic [BEAT_BITS-1:0]    rx;
    logic [BEAT_BITS-1:0]    pred;
    logic [BEAT_BITS+HW-1:0] ext;
    logic                    match;

    // ext[HW+n] is stream bit n of this beat; ext[HW-1-d] is d bits before it.
    always_comb begin
        rx = '0;
        for (int i = 0; i < BEAT_BITS; i++) begin
            rx[i] = data[(i / 16) * 16 + 15 - (i % 16)];
        end
        ext  = {rx, hist};
        pred = '0;
        for (int n = 0; n < BEAT_BITS; n++) begin
            pred[n] = sel ? (ext[n + HW - PN23_WIDTH] ^ ext[n + HW - PN23_TAP])
                          : (ext[n + HW - PN9_WIDTH]  ^ ext[n + HW - PN9_TAP]);
        end
        match = (pred == rx) && (|rx);
    end

    assign oos = (state == PN_OOS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PN_OOS;
            match_cnt <= '0;
            miss_cnt  <= '0;
            hist      <= '0;
            sel_d     <= 1'b0;
            err       <= 1'b0;
        end else begin
            sel_d <= sel;
            err   <= 1'b0;
            if (valid) begin
                hist <= rx[BEAT_BITS-1 -: HW];
            end
            if (sel != sel_d) begin
                state     <= PN_OOS;
                match_cnt <= '0;
                miss_cnt  <= '0;
            end else if (valid) begin
                if (match) begin
                    miss_cnt <= '0;
                    if (state == PN_OOS) begin
                        if (match_cnt == PN_CNT_W'(PN_THRESH - 1)) begin
                            state     <= PN_SYNC;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                end else begin
                    match_cnt <= '0;
                    if (state == PN_SYNC) begin
                        err <= 1'b1;
                        if (miss_cnt == PN_CNT_W'(PN_THRESH - 1)) begin
                            state    <= PN_OOS;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/jesd204_tpl_adc_deframer.sv
// JESD204 RX transport layer: lane beats -> per-channel samples, data formatting,
// optional per-channel PN monitor built only when JESD204_TPL_ADC_PNMON_EN is defined.
module jesd204_tpl_adc_deframer
    import jesd204_tpl_pkg::*;
#(
    parameter int NUM_LANES            = 4,
    parameter int NUM_CHANNELS         = 2,
    parameter int CONVERTER_RESOLUTION = 14,
    parameter int DATA_PATH_WIDTH      = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    link_valid,
    input  logic [NUM_LANES*32-1:0]                 link_data,
    input  logic [NUM_CHANNELS-1:0]                 enable,
    output logic [NUM_CHANNELS-1:0]                 adc_valid,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*16-1:0] adc_data,
    input  logic [NUM_CHANNELS-1:0]                 adc_dfmt_enable,
    input  logic [NUM_CHANNELS-1:0]                 adc_dfmt_type,
    input  logic [NUM_CHANNELS-1:0]                 adc_dfmt_se,
    input  logic [NUM_CHANNELS-1:0]                 adc_pn_sel,
    output logic [NUM_CHANNELS-1:0]                 adc_pn_oos,
    output logic [NUM_CHANNELS-1:0]                 adc_pn_err
);

    localparam int F  = frame_octets(NUM_LANES, NUM_CHANNELS);
    localparam int DW = DATA_PATH_WIDTH;
    localparam int SW = DW * 16;

    if (DW * F != OCTETS_PER_BEAT || DW < 2) begin : g_bad_cfg
        $error("DATA_PATH_WIDTH inconsistent with lane/channel geometry");
    end

    logic [NUM_CHANNELS*SW-1:0] deframed;
    logic [NUM_CHANNELS*SW-1:0] s1_data;
    logic [NUM_CHANNELS*SW-1:0] fmt_data;
    logic                       s1_valid;

    // Octet j of the frame stream (ch MSB, ch LSB, ...) sits on lane j/F at frame slot j%F.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        for (genvar k = 0; k < DW; k++) begin : g_smp
            for (genvar b = 0; b < 2; b++) begin : g_oct
                localparam int J    = 2 * c + b;
                localparam int LANE = J / F;
                localparam int OCT  = k * F + J % F;
                assign deframed[(c*DW+k)*16 + (1-b)*8 +: 8] = link_data[LANE*32 + OCT*8 +: 8];
            end
        end
    end

    function automatic logic [15:0] dfmt(input logic [15:0] raw, input logic typ, input logic se);
        logic [15:0] r;
        logic        msb;
        r   = raw >> (16 - CONVERTER_RESOLUTION);
        msb = r[CONVERTER_RESOLUTION-1] ^ typ;
        r[CONVERTER_RESOLUTION-1] = msb;
        for (int i = CONVERTER_RESOLUTION; i < 16; i++) begin
            r[i] = se & msb;
        end
        return r;
    endfunction

    always_comb begin
        fmt_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int k = 0; k < DW; k++) begin
                fmt_data[(c*DW+k)*16 +: 16] = adc_dfmt_enable[c]
                    ? dfmt(s1_data[(c*DW+k)*16 +: 16], adc_dfmt_type[c], adc_dfmt_se[c])
                    : s1_data[(c*DW+k)*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            adc_valid <= '0;
            adc_data  <= '0;
        end else begin
            s1_valid  <= link_valid;
            if (link_valid) begin
                s1_data <= deframed;
            end
            adc_valid <= {NUM_CHANNELS{s1_valid}} & enable;
            if (s1_valid) begin
                adc_data <= fmt_data;
            end
        end
    end

`ifdef JESD204_TPL_ADC_PNMON_EN
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pnmon
        jesd204_tpl_adc_pnmon #(
            .DATA_PATH_WIDTH(DW)
        ) u_pnmon (
            .clk   (clk),
            .rst   (reset),
            .valid (s1_valid),
            .sel   (adc_pn_sel[c]),
            .data  (s1_data[c*SW +: SW]),
            .oos   (adc_pn_oos[c]),
            .err   (adc_pn_err[c])
        );
    end
`else
    logic pn_sel_unused;
    assign pn_sel_unused = ^adc_pn_sel;
    assign adc_pn_oos    = '1;
    assign adc_pn_err    = '0;
`endif

endmodule

// File: tb/tb_jesd204_tpl_adc_deframer.sv
// Directed bench for jesd204_tpl_adc_deframer (L=4, M=2, N=14); PN checks follow
// JESD204_TPL_ADC_PNMON_EN, otherwise the tied-off monitor outputs are checked.
module tb_jesd204_tpl_adc_deframer;

    logic         clk;
    logic         reset;
    logic         link_valid;
    logic [127:0] link_data;
    logic [1:0]   enable;
    logic [1:0]   adc_valid;
    logic [127:0] adc_data;
    logic [1:0]   dfmt_enable;
    logic [1:0]   dfmt_type;
    logic [1:0]   dfmt_se;
    logic [1:0]   pn_sel;
    logic [1:0]   pn_oos;
    logic [1:0]   pn_err;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    logic [22:0] g_hist;
    logic [63:0] g_beat;

    jesd204_tpl_adc_deframer #(
        .NUM_LANES            (4),
        .NUM_CHANNELS         (2),
        .CONVERTER_RESOLUTION (14),
        .DATA_PATH_WIDTH      (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .link_valid      (link_valid),
        .link_data       (link_data),
        .enable          (enable),
        .adc_valid       (adc_valid),
        .adc_data        (adc_data),
        .adc_dfmt_enable (dfmt_enable),
        .adc_dfmt_type   (dfmt_type),
        .adc_dfmt_se     (dfmt_se),
        .adc_pn_sel      (pn_sel),
        .adc_pn_oos      (pn_oos),
        .adc_pn_err      (pn_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // F=1: ch0 MSB/LSB on lanes 0/1, ch1 MSB/LSB on lanes 2/3, sample k in octet k.
    function automatic logic [127:0] build_link(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            l[k*8 +: 8]      = a[k*16+8 +: 8];
            l[32 + k*8 +: 8] = a[k*16 +: 8];
            l[64 + k*8 +: 8] = b[k*16+8 +: 8];
            l[96 + k*8 +: 8] = b[k*16 +: 8];
        end
        return l;
    endfunction

    task automatic drive(input logic v, input logic [127:0] d);
        link_valid = v;
        link_data  = d;
        @(negedge clk);
    endtask

    task automatic gen_beat(input logic poly23);
        logic nb;
        for (int k = 0; k < 4; k++) begin
            for (int b = 15; b >= 0; b--) begin
                nb = poly23 ? (g_hist[22] ^ g_hist[17]) : (g_hist[8] ^ g_hist[4]);
                g_beat[k*16 + b] = nb;
                g_hist = {g_hist[21:0], nb};
            end
        end
    endtask

    task automatic pn_beat(input logic poly23, input logic corrupt);
        logic [63:0] s;
        gen_beat(poly23);
        s = g_beat;
        if (corrupt) s[15] = ~s[15];
        drive(1'b1, build_link(s, 64'h0));
        drive(1'b0, build_link(s, 64'h0));
    endtask

    task automatic lock_run(input logic poly23, input string tag);
        for (int i = 1; i <= 16; i++) begin
            pn_beat(poly23, 1'b0);
            if (i == 15) check({tag, "_pre"}, 128'(pn_oos), 128'(2'b11));
            if (i == 16) check({tag, "_lock"}, 128'(pn_oos), 128'(2'b10));
        end
    endtask

    initial begin
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] d;

        reset       = 1'b0;
        link_valid  = 1'b0;
        link_data   = '0;
        enable      = 2'b11;
        dfmt_enable = 2'b00;
        dfmt_type   = 2'b00;
        dfmt_se     = 2'b00;
        pn_sel      = 2'b00;
        g_hist      = 23'h1;
        g_beat      = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 128'(adc_valid), 128'(0));
        check("rst_data", adc_data, 128'(0));
        check("rst_oos", 128'(pn_oos), 128'(2'b11));
        check("rst_err", 128'(pn_err), 128'(0));
        reset = 1'b0;
        drive(1'b0, '0);

        // Deframe mapping, latency and hold
        d = {32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 32'h33221100};
        drive(1'b1, d);
        check("map_lat1", 128'(adc_valid), 128'(0));
        drive(1'b0, '0);
        check("map_valid", 128'(adc_valid), 128'(2'b11));
        check("map_data", adc_data, {64'hBBFF_AAEE_99DD_88CC, 64'h3377_2266_1155_0044});
        drive(1'b0, '0);
        check("map_vdrop", 128'(adc_valid), 128'(0));
        check("map_hold", adc_data, {64'hBBFF_AAEE_99DD_88CC, 64'h3377_2266_1155_0044});

        // Back-to-back random beats through the scoreboard
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                exp_q.push_back({b, a});
                drive(1'b1, build_link(a, b));
            end else begin
                drive(1'b0, '0);
            end
            if (i >= 1) begin
                check("b2b_valid", 128'(adc_valid), 128'(2'b11));
                check("b2b_data", adc_data, exp_q.pop_front());
            end
        end
        drive(1'b0, '0);
        check("b2b_idle", 128'(adc_valid), 128'(0));

        // Formatting: ch0 offset-binary + sign extend, ch1 passthrough
        dfmt_enable = 2'b01; dfmt_type = 2'b01; dfmt_se = 2'b01;
        drive(1'b1, build_link(64'h1234_FFFC_0000_8000, 64'h1234_5678_9ABC_DEF0));
        drive(1'b0, '0);
        check("fmt_ob_se", adc_data, {64'h1234_5678_9ABC_DEF0, 64'hE48D_1FFF_E000_0000});
        // ch0 two's complement + sign extend, ch1 two's complement zero-fill
        dfmt_enable = 2'b11; dfmt_type = 2'b00; dfmt_se = 2'b01;
        drive(1'b1, build_link(64'h0004_FFFC_7FFC_8000, 64'h5555_0003_FFFF_8000));
        drive(1'b0, '0);
        check("fmt_tc", adc_data, {64'h1555_0000_3FFF_2000, 64'h0001_FFFF_1FFF_E000});
        dfmt_enable = 2'b00; dfmt_type = 2'b00; dfmt_se = 2'b00;

        // Per-channel enable
        enable = 2'b01;
        drive(1'b1, d);
        drive(1'b0, '0);
        check("en_ch0_only", 128'(adc_valid), 128'(2'b01));
        enable = 2'b10;
        drive(1'b1, d);
        drive(1'b0, '0);
        check("en_ch1_only", 128'(adc_valid), 128'(2'b10));
        enable = 2'b11;

`ifdef JESD204_TPL_ADC_PNMON_EN
        // PN9 lock: one priming beat, then 16 matching beats
        pn_beat(1'b0, 1'b0);
        lock_run(1'b0, "pn9");
        check("pn9_noerr", 128'(pn_err), 128'(0));

        pn_beat(1'b0, 1'b1);
        check("pn_err_pulse", 128'(pn_err), 128'(2'b01));
        check("pn_err_sync", 128'(pn_oos), 128'(2'b10));
        drive(1'b0, '0);
        check("pn_err_clear", 128'(pn_err), 128'(0));
        pn_beat(1'b0, 1'b0);
        check("pn_after_err", 128'(pn_err), 128'(0));
        check("pn_still_sync", 128'(pn_oos), 128'(2'b10));

        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, '0);
            drive(1'b0, '0);
            if (i == 1)  check("zero_err", 128'(pn_err), 128'(2'b01));
            if (i == 15) check("zero_pre", 128'(pn_oos), 128'(2'b10));
            if (i == 16) check("zero_oos", 128'(pn_oos), 128'(2'b11));
        end

        // PN23 data with PN9 selected never locks
        for (int i = 0; i < 20; i++) pn_beat(1'b1, 1'b0);
        check("pn23_sel0", 128'(pn_oos), 128'(2'b11));
        pn_sel = 2'b01;
        drive(1'b0, '0);
        lock_run(1'b1, "pn23");
        pn_sel = 2'b00;
        check("sel_before", 128'(pn_oos), 128'(2'b10));
        drive(1'b0, '0);
        check("sel_toggle", 128'(pn_oos), 128'(2'b11));
        pn_sel = 2'b01;
        drive(1'b0, '0);
        lock_run(1'b1, "pn23_re");
`else
        for (int i = 0; i < 20; i++) pn_beat(1'b1, 1'b0);
        check("nomon_oos", 128'(pn_oos), 128'(2'b11));
        check("nomon_err", 128'(pn_err), 128'(0));
        pn_sel = 2'b01;
        pn_beat(1'b1, 1'b1);
        check("nomon_oos_sel", 128'(pn_oos), 128'(2'b11));
        check("nomon_err_sel", 128'(pn_err), 128'(0));
`endif

        // Reset mid-stream while a beat is in flight
        pn_beat(1'b1, 1'b0);
        gen_beat(1'b1);
        link_valid = 1'b1;
        link_data  = build_link(g_beat, 64'h0);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_valid", 128'(adc_valid), 128'(0));
        check("mid_rst_data", adc_data, 128'(0));
        check("mid_rst_oos", 128'(pn_oos), 128'(2'b11));
        check("mid_rst_err", 128'(pn_err), 128'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, '0);
        gen_beat(1'b1);
        drive(1'b1, build_link(g_beat, 64'h0));
        check("post_rst_lat", 128'(adc_valid), 128'(0));
        drive(1'b0, '0);
        check("post_rst_valid", 128'(adc_valid), 128'(2'b11));
        check("post_rst_data", adc_data, {64'h0, g_beat});
`ifdef JESD204_TPL_ADC_PNMON_EN
        lock_run(1'b1, "rst_relock");
`else
        check("post_rst_oos", 128'(pn_oos), 128'(2'b11));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
